// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI3 slave RAM with independent read/write FSMs, one transaction each, FIXED/INCR bursts up to 16 beats.
// Build macro AXI_RAM_RD_DELAY_EN inserts RD_DELAY idle cycles before the first read beat.
module axi_ram_slave #(
  parameter int ADDR_BITS = 12,
  parameter int RD_DELAY  = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int WORDS = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] IDX_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

`ifdef AXI_RAM_RD_DELAY_EN
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;
  localparam logic [3:0] DLY_LAST = 4'(RD_DELAY - 1);
`else
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd2} r_state_t;
`endif
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

  logic [31:0] mem [WORDS];

  r_state_t              r_state, r_next;
  logic [3:0]            rid_q;
  logic [ADDR_BITS-1:0]  ridx, ridx_next, rd_addr;
  logic [3:0]            rlen, rbeat;
  logic                  r_fixed;
  logic [31:0]           rdata_q;
  logic                  rd_load;
  logic                  r_last_beat;
  logic [ADDR_BITS-1:0]  ar_idx;
`ifdef AXI_RAM_RD_DELAY_EN
  logic [3:0]            dly_cnt;
`endif

  w_state_t              w_state, w_next;
  logic [3:0]            bid_q;
  logic [ADDR_BITS-1:0]  widx, widx_next;
  logic [3:0]            wlen, wbeat;
  logic                  w_fixed;
  logic                  w_err;
  logic                  w_last_beat;
  logic                  w_fire;

  logic                  unused_ok;
  assign unused_ok = ^{arsize, arlock, arcache, arprot, araddr[31:ADDR_BITS+2], araddr[1:0], arlen[7:4],
                       awsize, awlock, awcache, awprot, awaddr[31:ADDR_BITS+2], awaddr[1:0], awlen[7:4],
                       wid, 4'(RD_DELAY)};

  assign ar_idx      = araddr[ADDR_BITS+1:2];
  assign r_last_beat = (rbeat == rlen);
  assign ridx_next   = r_fixed ? ridx : ridx + IDX_ONE;

  // ---------------- read FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // rdata is a register: it is loaded one cycle ahead of each beat it presents.
  always_comb begin
    r_next  = r_state;
    rd_load = 1'b0;
    rd_addr = ridx;
    case (r_state)
      R_IDLE: begin
        if (arvalid) begin
`ifdef AXI_RAM_RD_DELAY_EN
          if (RD_DELAY == 0) begin
            r_next  = R_DATA;
            rd_load = 1'b1;
            rd_addr = ar_idx;
          end else begin
            r_next = R_WAIT;
          end
`else
          r_next  = R_DATA;
          rd_load = 1'b1;
          rd_addr = ar_idx;
`endif
        end
      end
`ifdef AXI_RAM_RD_DELAY_EN
      R_WAIT: begin
        if (dly_cnt == DLY_LAST) begin
          r_next  = R_DATA;
          rd_load = 1'b1;
        end
      end
`endif
      R_DATA: begin
        if (rready) begin
          if (r_last_beat) begin
            r_next = R_IDLE;
          end else begin
            rd_load = 1'b1;
            rd_addr = ridx_next;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rid_q   <= '0;
      ridx    <= '0;
      rlen    <= '0;
      rbeat   <= '0;
      r_fixed <= 1'b0;
      rdata_q <= '0;
`ifdef AXI_RAM_RD_DELAY_EN
      dly_cnt <= '0;
`endif
    end else begin
      if (r_state == R_IDLE && arvalid) begin
        rid_q   <= arid;
        ridx    <= ar_idx;
        rlen    <= arlen[3:0];
        rbeat   <= '0;
        r_fixed <= (arburst == 2'b00);
`ifdef AXI_RAM_RD_DELAY_EN
        dly_cnt <= '0;
`endif
      end
`ifdef AXI_RAM_RD_DELAY_EN
      if (r_state == R_WAIT) dly_cnt <= dly_cnt + 4'd1;
`endif
      if (r_state == R_DATA && rready && !r_last_beat) begin
        ridx  <= ridx_next;
        rbeat <= rbeat + 4'd1;
      end
      // Same-cycle write to this word is not yet visible here: old data wins.
      if (rd_load) rdata_q <= mem[rd_addr];
    end
  end

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);
  assign rlast   = rvalid && r_last_beat;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = 2'b00;

  // ---------------- write FSM ----------------
  assign w_last_beat = (wbeat == wlen);
  assign w_fire      = (w_state == W_DATA) && wvalid;
  assign widx_next   = w_fixed ? widx : widx + IDX_ONE;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (awvalid) w_next = W_DATA;
      W_DATA:  if (wvalid && w_last_beat) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bid_q   <= '0;
      widx    <= '0;
      wlen    <= '0;
      wbeat   <= '0;
      w_fixed <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      if (w_state == W_IDLE && awvalid) begin
        bid_q   <= awid;
        widx    <= awaddr[ADDR_BITS+1:2];
        wlen    <= awlen[3:0];
        wbeat   <= '0;
        w_fixed <= (awburst == 2'b00);
        w_err   <= 1'b0;
      end
      // The beat count, not wlast, ends the burst; a wlast mismatch only taints the response.
      if (w_fire) begin
        if (wlast != w_last_beat) w_err <= 1'b1;
        if (!w_last_beat) begin
          widx  <= widx_next;
          wbeat <= wbeat + 4'd1;
        end
      end
      if (w_state == W_RESP && bready) w_err <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bid     = bid_q;
  assign bresp   = (bvalid && w_err) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: directed and random bursts against a word-array reference model.
module tb_axi_ram_slave;

  localparam int AB       = 12;
  localparam int RD_DLY   = 3;
`ifdef AXI_RAM_RD_DELAY_EN
  localparam int EXP_LAT  = 1 + RD_DLY;
`else
  localparam int EXP_LAT  = 1;
`endif

  logic        aclk, aresetn;
  logic [3:0]  arid;    logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0]  arburst; logic [1:0]  arlock; logic [3:0] arcache; logic [2:0] arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;     logic [31:0] rdata;  logic [1:0] rresp;  logic rlast, rvalid, rready;
  logic [3:0]  awid;    logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0]  awburst; logic [1:0]  awlock; logic [3:0] awcache; logic [2:0] awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;     logic [31:0] wdata;  logic [3:0] wstrb;  logic wlast, wvalid, wready;
  logic [3:0]  bid;     logic [1:0]  bresp;  logic bvalid, bready;

  int vectors = 0;
  int miscompares = 0;
  int gap_max = 0;

  logic [31:0] mdl [1 << AB];
  logic [31:0] wbuf_dat  [16];
  logic [3:0]  wbuf_strb [16];

  axi_ram_slave #(.ADDR_BITS(AB), .RD_DELAY(RD_DLY)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drives one write burst from wbuf_*; wlast is raised on the final beat and also on bad_beat.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input int bad_beat);
    int n, cyc;
    logic hs, err, lst;
    logic [AB-1:0] idx;
    n   = int'(len[3:0]) + 1;
    idx = addr[AB+1:2];
    err = 1'b0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2;
    awlock = 2'($urandom); awcache = 4'($urandom); awprot = 3'($urandom);
    awvalid = 1'b1;
    cyc = 0;
    do begin hs = awready; tick(); cyc++; end while (!hs && cyc < 50);
    awvalid = 1'b0;
    chk("aw_handshake", hs, 1);
    chk("wready_after_aw", wready, 1);
    chk("awready_busy", awready, 0);
    for (int i = 0; i < n; i++) begin
      wvalid = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick();
      lst   = (i == bad_beat) || (i == n - 1);
      wdata = wbuf_dat[i]; wstrb = wbuf_strb[i]; wlast = lst; wid = 4'($urandom);
      wvalid = 1'b1;
      err |= (lst != (i == n - 1));
      cyc = 0;
      do begin hs = wready; tick(); cyc++; end while (!hs && cyc < 50);
      chk("w_handshake", hs, 1);
      for (int b = 0; b < 4; b++)
        if (wbuf_strb[i][b]) mdl[idx][8*b +: 8] = wbuf_dat[i][8*b +: 8];
      if (burst != 2'b00) idx = idx + 1'b1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_last_w", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, err ? 2'b10 : 2'b00);
    repeat ($urandom_range(0, 2)) begin tick(); chk("bvalid_held", bvalid, 1); end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_cleared", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask

  // mode 0: rready always high, 1: alternating starting low, 2: random. abort_beat >= 0 stops early.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input int mode, input int abort_beat);
    int n, cyc, lat, beat;
    logic hs, done, aborted;
    logic [AB-1:0] idx;
    n   = int'(len[3:0]) + 1;
    idx = addr[AB+1:2];
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2;
    arlock = 2'($urandom); arcache = 4'($urandom); arprot = 3'($urandom);
    arvalid = 1'b1; rready = 1'b0;
    cyc = 0;
    do begin hs = arready; tick(); cyc++; end while (!hs && cyc < 50);
    arvalid = 1'b0;
    chk("ar_handshake", hs, 1);
    chk("arready_busy", arready, 0);
    lat = 1;
    while (!rvalid && lat < 40) begin tick(); lat++; end
    chk("rd_latency", lat, EXP_LAT);
    beat = 0; cyc = 0; done = 1'b0; aborted = 1'b0;
    while (!done && !aborted && cyc < 300) begin
      if (abort_beat >= 0 && beat == abort_beat) begin
        aborted = 1'b1;
      end else begin
        chk("rvalid", rvalid, 1);
        if (rvalid) begin
          chk("rdata", rdata, mdl[idx]);
          chk("rlast", rlast, beat == n - 1);
          chk("rid", rid, id);
          chk("rresp", rresp, 0);
        end
        case (mode)
          0:       rready = 1'b1;
          1:       rready = cyc[0];
          default: rready = 1'($urandom_range(0, 1));
        endcase
        hs = rvalid && rready;
        tick();
        cyc++;
        if (hs) begin
          if (beat == n - 1) done = 1'b1;
          else begin
            beat++;
            if (burst != 2'b00) idx = idx + 1'b1;
          end
        end
      end
    end
    rready = 1'b0;
    if (!aborted) begin
      chk("rd_completed", done, 1);
      chk("rvalid_end", rvalid, 0);
      chk("arready_end", arready, 1);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    logic [1:0]  bt;
    aresetn = 1'b0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0; arcache = 0; arprot = 0;
    arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0; awprot = 0;
    awvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    repeat (3) tick();
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    aresetn = 1'b1;
    tick();

    // Fill the whole memory so every later read has defined contents.
    gap_max = 0;
    for (int b = 0; b < (1 << AB) / 16; b++) begin
      for (int i = 0; i < 16; i++) begin wbuf_dat[i] = $urandom; wbuf_strb[i] = 4'hF; end
      do_write(32'(b * 64), 4'h0, 8'd15, 2'b01, -1);
    end

    // Single write then read through aliased address.
    wbuf_dat[0] = 32'hDEADBEEF; wbuf_strb[0] = 4'hF;
    do_write(32'h1FC0_0010, 4'h3, 8'd0, 2'b01, -1);
    do_read(32'h1FC0_0010, 4'h5, 8'd0, 2'b01, 0, -1);

    // Strobed merge: expect 0xAA22CC44.
    wbuf_dat[0] = 32'hAABBCCDD; wbuf_strb[0] = 4'hF;
    do_write(32'h0000_0040, 4'h1, 8'd0, 2'b01, -1);
    wbuf_dat[0] = 32'h11223344; wbuf_strb[0] = 4'b0101;
    do_write(32'h0000_0040, 4'h2, 8'd0, 2'b01, -1);
    do_read(32'h0000_0040, 4'h7, 8'd0, 2'b01, 0, -1);

    // INCR burst at word 4, read back with rready toggling.
    for (int i = 0; i < 4; i++) begin wbuf_dat[i] = 32'(i + 1); wbuf_strb[i] = 4'hF; end
    do_write(32'h0000_0010, 4'h4, 8'd3, 2'b01, -1);
    do_read(32'h0000_0010, 4'h9, 8'd3, 2'b01, 1, -1);

    // Early wlast on beat 1 of a 3-beat burst.
    for (int i = 0; i < 3; i++) begin wbuf_dat[i] = $urandom; wbuf_strb[i] = 4'hF; end
    do_write(32'h0000_0100, 4'hA, 8'd2, 2'b01, 1);
    do_read(32'h0000_0100, 4'hB, 8'd2, 2'b01, 0, -1);

    // Wrap past the top of memory, and a FIXED burst.
    for (int i = 0; i < 4; i++) begin wbuf_dat[i] = $urandom; wbuf_strb[i] = 4'hF; end
    do_write(32'h0000_3FF8, 4'hC, 8'd3, 2'b01, -1);
    do_read(32'h0000_3FF8, 4'hD, 8'd3, 2'b01, 2, -1);
    for (int i = 0; i < 4; i++) begin wbuf_dat[i] = $urandom; wbuf_strb[i] = 4'($urandom); end
    do_write(32'h0000_0200, 4'hE, 8'd3, 2'b00, -1);
    do_read(32'h0000_0200, 4'hF, 8'd3, 2'b00, 2, -1);

    // Random traffic, including junk upper len bits and upper address bits.
    gap_max = 2;
    for (int t = 0; t < 16; t++) begin
      a  = $urandom;
      l  = 8'($urandom);
      bt = 2'($urandom_range(0, 2));
      for (int i = 0; i < 16; i++) begin wbuf_dat[i] = $urandom; wbuf_strb[i] = 4'($urandom); end
      do_write(a, 4'($urandom), l, bt, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1);
      do_read(a, 4'($urandom), l, bt, 2, -1);
    end

    // Reset in the middle of an 8-beat read.
    do_read(32'h0000_0400, 4'h6, 8'd7, 2'b01, 0, 2);
    aresetn = 1'b0;
    #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_arready", arready, 1);
    chk("midrst_awready", awready, 1);
    chk("midrst_rlast", rlast, 0);
    repeat (2) tick();
    aresetn = 1'b1;
    tick();
    chk("postrst_arready", arready, 1);
    do_read(32'h0000_0400, 4'h8, 8'd3, 2'b01, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
